// File: rtl/score_cal_point_serializer_pkg.sv
// Shared definitions for the calibration-point serializer: default geometry,
// FSM state encoding and a packed-window element selector.
package score_cal_point_serializer_pkg;

  localparam int unsigned CalWidth = 8;
  localparam int unsigned CalDepth = 5;
  localparam int unsigned CalIdxW  = 3;
  localparam int unsigned CalWinW  = CalWidth * CalDepth;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } ser_state_e;

  // Element k of a default-geometry packed window, element k at [k*CalWidth +: CalWidth].
  function automatic logic [CalWidth-1:0] cal_elem(input logic [CalWinW-1:0] win,
                                                   input int unsigned k);
    return win[k*CalWidth +: CalWidth];
  endfunction

endpackage

// File: rtl/score_cal_point_serializer_if.sv
// Window load / beat stream bundle between a producer (master) and the serializer (slave).
interface score_cal_point_serializer_if
  import score_cal_point_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = CalWidth,
  parameter int unsigned DEPTH = CalDepth
);

  logic                   load;
  logic [WIDTH*DEPTH-1:0] data_in_a_all;
  logic [WIDTH*DEPTH-1:0] data_in_b_all;
  logic                   out_ready;
  logic                   cal_point_rdy;
  logic [WIDTH-1:0]       data_out_a_tem;
  logic [WIDTH-1:0]       data_out_b_tem;
  logic                   busy;
  logic                   done;

  modport master (
    output load, data_in_a_all, data_in_b_all, out_ready,
    input  cal_point_rdy, data_out_a_tem, data_out_b_tem, busy, done
  );

  modport slave (
    input  load, data_in_a_all, data_in_b_all, out_ready,
    output cal_point_rdy, data_out_a_tem, data_out_b_tem, busy, done
  );

endinterface

// File: rtl/score_cal_point_lane_mux.sv
// Registered DEPTH:1 selector for one sample lane. The output register loads the
// selected element on en_i and is forced to zero on clr_i or rst.
module score_cal_point_lane_mux
  import score_cal_point_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = CalWidth,
  parameter int unsigned DEPTH = CalDepth,
  parameter int unsigned IDX_W = CalIdxW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [WIDTH*DEPTH-1:0] window_i,
  input  logic [IDX_W-1:0]       sel_i,
  output logic [WIDTH-1:0]       q_o
);

  logic [WIDTH-1:0] elems [DEPTH];
  logic [WIDTH-1:0] pick;

  for (genvar k = 0; k < DEPTH; k++) begin : g_unpack
    assign elems[k] = window_i[k*WIDTH +: WIDTH];
  end

  // Out-of-range selects read as zero rather than undefined.
  always_comb begin
    pick = '0;
    if (32'(sel_i) < DEPTH) begin
      pick = elems[sel_i];
    end
  end

  // Output register: clear has priority over load.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= pick;
    end
  end

endmodule

// File: rtl/score_cal_point_serializer.sv
// Captures a packed window of DEPTH A/B point pairs and streams them out highest
// index first, one pair per accepted beat, so a newest-into-index-0 shift buffer
// downstream rebuilds the same packed vector.
module score_cal_point_serializer
  import score_cal_point_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = CalWidth,
  parameter int unsigned DEPTH = CalDepth,
  parameter int unsigned IDX_W = CalIdxW
) (
  input logic                          clk,
  input logic                          rst,
  score_cal_point_serializer_if.slave  bus
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  ser_state_e             state_q;
  logic [IDX_W-1:0]       index_q;
  logic [WIDTH*DEPTH-1:0] cap_a_q;
  logic [WIDTH*DEPTH-1:0] cap_b_q;
  logic                   rdy_q;
  logic                   done_q;

  logic                   mux_en;
  logic                   mux_clr;
  logic [IDX_W-1:0]       mux_sel;
  logic [WIDTH*DEPTH-1:0] win_a;
  logic [WIDTH*DEPTH-1:0] win_b;
  logic [WIDTH-1:0]       out_a;
  logic [WIDTH-1:0]       out_b;

  // Sequencer: window capture, index countdown, valid and done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      index_q <= '0;
      cap_a_q <= '0;
      cap_b_q <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.load) begin
            cap_a_q <= bus.data_in_a_all;
            cap_b_q <= bus.data_in_b_all;
            index_q <= LastIdx;
            rdy_q   <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (bus.out_ready) begin
            if (index_q != '0) begin
              index_q <= index_q - 1'b1;
            end else begin
              done_q <= 1'b1;
              // A load coinciding with the final transfer chains the next window.
              if (bus.load) begin
                cap_a_q <= bus.data_in_a_all;
                cap_b_q <= bus.data_in_b_all;
                index_q <= LastIdx;
              end else begin
                rdy_q   <= 1'b0;
                state_q <= StIdle;
              end
            end
          end
        end
      endcase
    end
  end

  // Lane-mux control: select the element that becomes visible after this edge,
  // taking it straight from the inputs when a capture happens on the same edge.
  always_comb begin
    mux_en  = 1'b0;
    mux_clr = 1'b0;
    mux_sel = index_q;
    win_a   = cap_a_q;
    win_b   = cap_b_q;
    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          mux_en  = 1'b1;
          mux_sel = LastIdx;
          win_a   = bus.data_in_a_all;
          win_b   = bus.data_in_b_all;
        end
      end
      StSend: begin
        if (bus.out_ready) begin
          if (index_q != '0) begin
            mux_en  = 1'b1;
            mux_sel = index_q - 1'b1;
          end else if (bus.load) begin
            mux_en  = 1'b1;
            mux_sel = LastIdx;
            win_a   = bus.data_in_a_all;
            win_b   = bus.data_in_b_all;
          end else begin
            mux_clr = 1'b1;
          end
        end
      end
    endcase
  end

  score_cal_point_lane_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_lane_a (
    .clk      (clk),
    .rst      (rst),
    .en_i     (mux_en),
    .clr_i    (mux_clr),
    .window_i (win_a),
    .sel_i    (mux_sel),
    .q_o      (out_a)
  );

  score_cal_point_lane_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_lane_b (
    .clk      (clk),
    .rst      (rst),
    .en_i     (mux_en),
    .clr_i    (mux_clr),
    .window_i (win_b),
    .sel_i    (mux_sel),
    .q_o      (out_b)
  );

  assign bus.cal_point_rdy  = rdy_q;
  assign bus.busy           = (state_q == StSend);
  assign bus.done           = done_q;
  assign bus.data_out_a_tem = out_a;
  assign bus.data_out_b_tem = out_b;

endmodule

// File: tb/tb_score_cal_point_serializer.sv
// Self-checking bench for the calibration-point serializer.
module tb_score_cal_point_serializer;
  import score_cal_point_serializer_pkg::*;

  localparam int W = 8;
  localparam int D = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_cal_point_serializer_if #(.WIDTH(W), .DEPTH(D)) bus ();

  score_cal_point_serializer #(
    .WIDTH (W),
    .DEPTH (D),
    .IDX_W (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [W*D-1:0] basic_a;
  logic [W*D-1:0] basic_b;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W*D-1:0] pack5(input int e4, input int e3, input int e2,
                                           input int e1, input int e0);
    return {8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic idle_inputs();
    bus.load      = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.load = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_in_a_all = '0;
    bus.data_in_b_all = '0;
    step();
    step();
    checks++;
    if ({bus.cal_point_rdy, bus.busy, bus.done, bus.data_out_a_tem, bus.data_out_b_tem} !== '0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b busy=%b done=%b a=%0d b=%0d want all 0",
               bus.cal_point_rdy, bus.busy, bus.done, bus.data_out_a_tem, bus.data_out_b_tem);
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    checks++;
    if ({bus.cal_point_rdy, bus.busy, bus.done, bus.data_out_a_tem, bus.data_out_b_tem} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset got rdy=%b busy=%b done=%b want 0",
               bus.cal_point_rdy, bus.busy, bus.done);
    end
  endtask

  // Plain window with loopback reconstruction.
  task automatic test_basic();
    logic [W*D-1:0] lb_a = '0;
    logic [W*D-1:0] lb_b = '0;
    bus.data_in_a_all = basic_a;
    bus.data_in_b_all = basic_b;
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int k = D - 1; k >= 0; k--) begin
      checks++;
      if ({bus.cal_point_rdy, bus.busy, bus.done, bus.data_out_a_tem, bus.data_out_b_tem} !==
          {3'b110, cal_elem(basic_a, k), cal_elem(basic_b, k)}) begin
        failures++;
        $display("FAIL basic_beat k=%0d got rdy=%b done=%b a=%0d b=%0d want a=%0d b=%0d", k,
                 bus.cal_point_rdy, bus.done, bus.data_out_a_tem, bus.data_out_b_tem,
                 cal_elem(basic_a, k), cal_elem(basic_b, k));
      end
      lb_a = {lb_a[W*(D-1)-1:0], bus.data_out_a_tem};
      lb_b = {lb_b[W*(D-1)-1:0], bus.data_out_b_tem};
      step();
    end
    checks++;
    if ({bus.done, bus.cal_point_rdy, bus.busy} !== 3'b100) begin
      failures++;
      $display("FAIL basic_done got done=%b rdy=%b busy=%b want 1 0 0",
               bus.done, bus.cal_point_rdy, bus.busy);
    end
    checks++;
    if (lb_a !== basic_a || lb_b !== basic_b) begin
      failures++;
      $display("FAIL basic_loopback got a=%h b=%h want a=%h b=%h", lb_a, lb_b, basic_a, basic_b);
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_width got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_stall();
    int stalls = 0;
    int cyc = 1;
    int k = D - 1;
    bus.data_in_a_all = basic_a;
    bus.data_in_b_all = basic_b;
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    while (k >= 0 && cyc < 20) begin
      checks++;
      if ({bus.cal_point_rdy, bus.done, bus.data_out_a_tem, bus.data_out_b_tem} !==
          {2'b10, cal_elem(basic_a, k), cal_elem(basic_b, k)}) begin
        failures++;
        $display("FAIL stall_beat k=%0d cyc=%0d got rdy=%b a=%0d b=%0d want a=%0d b=%0d", k, cyc,
                 bus.cal_point_rdy, bus.data_out_a_tem, bus.data_out_b_tem,
                 cal_elem(basic_a, k), cal_elem(basic_b, k));
      end
      if (k == 2 && stalls < 3) begin
        bus.out_ready = 1'b0;
        stalls++;
      end else begin
        bus.out_ready = 1'b1;
        k--;
      end
      step();
      cyc++;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.cal_point_rdy !== 1'b0 || cyc != D + 1 + 3) begin
      failures++;
      $display("FAIL stall_done got done=%b rdy=%b cyc=%0d want 1 0 %0d",
               bus.done, bus.cal_point_rdy, cyc, D + 4);
    end
    step();
  endtask

  task automatic test_ignored_load();
    bus.data_in_a_all = basic_a;
    bus.data_in_b_all = basic_b;
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int k = D - 1; k >= 0; k--) begin
      checks++;
      if ({bus.cal_point_rdy, bus.data_out_a_tem, bus.data_out_b_tem} !==
          {1'b1, cal_elem(basic_a, k), cal_elem(basic_b, k)}) begin
        failures++;
        $display("FAIL ignload_beat k=%0d got rdy=%b a=%0d b=%0d want a=%0d b=%0d", k,
                 bus.cal_point_rdy, bus.data_out_a_tem, bus.data_out_b_tem,
                 cal_elem(basic_a, k), cal_elem(basic_b, k));
      end
      if (k == D - 2) begin
        bus.load = 1'b1;
        bus.data_in_a_all = {D{8'd7}};
      end else begin
        bus.load = 1'b0;
      end
      step();
    end
    bus.load = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.cal_point_rdy !== 1'b0) begin
      failures++;
      $display("FAIL ignload_done got done=%b rdy=%b want 1 0", bus.done, bus.cal_point_rdy);
    end
    step();
    checks++;
    if (bus.cal_point_rdy !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL ignload_idle got rdy=%b busy=%b want 0 0", bus.cal_point_rdy, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W*D-1:0] nxt_a = pack5(2, 51, 0, 255, 1);
    logic [W*D-1:0] nxt_b = 40'($urandom) ^ {8'($urandom), 32'h0};
    bus.data_in_a_all = basic_a;
    bus.data_in_b_all = basic_b;
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int k = D - 1; k >= 0; k--) begin
      if (k == 0) begin
        bus.load = 1'b1;
        bus.data_in_a_all = nxt_a;
        bus.data_in_b_all = nxt_b;
      end
      step();
    end
    bus.load = 1'b0;
    checks++;
    if ({bus.done, bus.cal_point_rdy, bus.data_out_a_tem, bus.data_out_b_tem} !==
        {2'b11, 8'd2, cal_elem(nxt_b, 4)}) begin
      failures++;
      $display("FAIL b2b_join got done=%b rdy=%b a=%0d b=%0d want 1 1 2 %0d", bus.done,
               bus.cal_point_rdy, bus.data_out_a_tem, bus.data_out_b_tem, cal_elem(nxt_b, 4));
    end
    step();
    for (int k = D - 2; k >= 0; k--) begin
      checks++;
      if ({bus.done, bus.cal_point_rdy, bus.data_out_a_tem, bus.data_out_b_tem} !==
          {2'b01, cal_elem(nxt_a, k), cal_elem(nxt_b, k)}) begin
        failures++;
        $display("FAIL b2b_beat k=%0d got done=%b rdy=%b a=%0d b=%0d want a=%0d b=%0d", k,
                 bus.done, bus.cal_point_rdy, bus.data_out_a_tem, bus.data_out_b_tem,
                 cal_elem(nxt_a, k), cal_elem(nxt_b, k));
      end
      step();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.cal_point_rdy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done got done=%b rdy=%b want 1 0", bus.done, bus.cal_point_rdy);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.data_in_a_all = basic_a;
    bus.data_in_b_all = basic_b;
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    step();
    step();
    checks++;
    if ({bus.data_out_a_tem, bus.data_out_b_tem} !== {8'd26, 8'd99}) begin
      failures++;
      $display("FAIL rstmid_pre got a=%0d b=%0d want 26 99", bus.data_out_a_tem,
               bus.data_out_b_tem);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.cal_point_rdy, bus.busy, bus.done, bus.data_out_a_tem, bus.data_out_b_tem} !== '0) begin
        failures++;
        $display("FAIL rstmid_abort i=%0d got rdy=%b busy=%b done=%b a=%0d b=%0d want all 0", i,
                 bus.cal_point_rdy, bus.busy, bus.done, bus.data_out_a_tem, bus.data_out_b_tem);
      end
      step();
    end
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    checks++;
    if ({bus.cal_point_rdy, bus.data_out_a_tem, bus.data_out_b_tem} !== {1'b1, 8'd12, 8'd24}) begin
      failures++;
      $display("FAIL rstmid_reload got rdy=%b a=%0d b=%0d want 1 12 24", bus.cal_point_rdy,
               bus.data_out_a_tem, bus.data_out_b_tem);
    end
    for (int i = 0; i < D; i++) step();
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_done got done=%b want 1", bus.done);
    end
    step();
  endtask

  // Random loads/back-pressure against a beat-queue model with loopback check.
  task automatic test_random();
    logic [2*W-1:0] exp_q[$];
    logic [W*D-1:0] win_a_q[$];
    logic [W*D-1:0] win_b_q[$];
    logic [W*D-1:0] lb_a = '0;
    logic [W*D-1:0] lb_b = '0;
    logic [2*W-1:0] beat;
    logic [W*D-1:0] ra;
    logic [W*D-1:0] rb;
    logic exp_done = 1'b0;
    logic exp_rdy;
    logic or_v;
    logic ld;
    logic xfer;
    logic fin;
    idle_inputs();
    for (int i = 0; i < 8; i++) step();
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_rdy = (exp_q.size() != 0);
      checks++;
      if ({bus.cal_point_rdy, bus.busy, bus.done} !== {exp_rdy, exp_rdy, exp_done}) begin
        failures++;
        $display("FAIL rand_flags cyc=%0d got rdy=%b busy=%b done=%b want %b %b %b", cyc,
                 bus.cal_point_rdy, bus.busy, bus.done, exp_rdy, exp_rdy, exp_done);
      end
      beat = exp_rdy ? exp_q[0] : '0;
      checks++;
      if ({bus.data_out_a_tem, bus.data_out_b_tem} !== beat) begin
        failures++;
        $display("FAIL rand_data cyc=%0d got a=%0d b=%0d want a=%0d b=%0d", cyc,
                 bus.data_out_a_tem, bus.data_out_b_tem, beat[2*W-1:W], beat[W-1:0]);
      end
      or_v = (cyc >= 560) || ($urandom_range(0, 3) != 0);
      ld = (cyc < 560) && ($urandom_range(0, 3) == 0);
      ra = {8'($urandom), 32'($urandom)};
      rb = {8'($urandom), 32'($urandom)};
      bus.out_ready = or_v;
      bus.load = ld;
      bus.data_in_a_all = ra;
      bus.data_in_b_all = rb;
      xfer = exp_rdy && or_v;
      fin = xfer && (exp_q.size() == 1);
      exp_done = fin;
      if (xfer) begin
        beat = exp_q.pop_front();
        lb_a = {lb_a[W*(D-1)-1:0], beat[2*W-1:W]};
        lb_b = {lb_b[W*(D-1)-1:0], beat[W-1:0]};
      end
      if (fin) begin
        ra = win_a_q.pop_front();
        rb = win_b_q.pop_front();
        checks++;
        if (lb_a !== ra || lb_b !== rb) begin
          failures++;
          $display("FAIL rand_loopback cyc=%0d got a=%h b=%h want a=%h b=%h", cyc, lb_a, lb_b,
                   ra, rb);
        end
      end
      if (ld && (!exp_rdy || fin)) begin
        win_a_q.push_back(bus.data_in_a_all);
        win_b_q.push_back(bus.data_in_b_all);
        for (int k = D - 1; k >= 0; k--) begin
          exp_q.push_back({cal_elem(bus.data_in_a_all, k), cal_elem(bus.data_in_b_all, k)});
        end
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    basic_a = pack5(12, 33, 156, 26, 199);
    basic_b = pack5(24, 66, 224, 99, 96);
    test_reset();
    test_basic();
    test_stall();
    test_ignored_load();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
